// File: rtl/chocorol_pkg.sv
// chocorol_pkg: shared definitions for the chocorol sequential ALU.
//   - opcode constants
//   - controller state encoding
//   - instruction field offset helpers (instr = {DA, DB, DD, opcode}, DA in MSBs)
package chocorol_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_MUL = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

  function automatic int f_instr_w(input int addr_w, input int op_w);
    return 3 * addr_w + op_w;
  endfunction

  function automatic int f_da_lsb(input int addr_w, input int op_w);
    return 2 * addr_w + op_w;
  endfunction

  function automatic int f_db_lsb(input int addr_w, input int op_w);
    return addr_w + op_w;
  endfunction

  function automatic int f_dd_lsb(input int addr_w, input int op_w);
    // DD sits directly above the opcode field; addr_w kept for symmetry.
    return op_w + (addr_w - addr_w);
  endfunction

endpackage

// File: rtl/chocorol_mul_seq.sv
// chocorol_mul_seq: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   i_start      load operands, clear accumulator and counter
//   i_a, i_b     multiplicand / multiplier (sampled on i_start)
//   o_done       high during the final iteration cycle (the DATA_W-th)
//   o_product    accumulator; holds the low DATA_W bits of the product once
//                the final iteration has been clocked
module chocorol_mul_seq
  import chocorol_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  logic [DATA_W-1:0] w_acc_next;
  logic              w_last;

  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  assign w_last     = r_busy && (r_cnt == CNT_W'(DATA_W - 1));

  assign o_done    = w_last;
  assign o_product = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/chocorol_seq.sv
// chocorol_seq: clocked ALU with a register-file data memory.
// Instructions {DA, DB, DD, opcode} arrive over a valid/ready handshake; operands
// Mem[DA], Mem[DB] are latched, the op executes (MUL iterates DATA_W cycles),
// and the result is written to Mem[DD] and presented on q_final.
// Ports:
//   clk, rst_n                   clock / asynchronous active-low reset
//   instr_valid/instr_ready/instr instruction handshake
//   ld_en/ld_addr/ld_data        memory preload (honoured in IDLE only)
//   q_final, q_valid             last result and its one-cycle update pulse
//   q_zero, q_carry              result == 0; ADD carry-out / SUB borrow
//   q_err                        one-cycle pulse for an illegal opcode
module chocorol_seq
  import chocorol_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int OP_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [3*ADDR_W+OP_W-1:0]  instr,
  input  logic                      ld_en,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [DATA_W-1:0]         q_final,
  output logic                      q_valid,
  output logic                      q_zero,
  output logic                      q_carry,
  output logic                      q_err
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DA_LSB = f_da_lsb(ADDR_W, OP_W);
  localparam int DB_LSB = f_db_lsb(ADDR_W, OP_W);
  localparam int DD_LSB = f_dd_lsb(ADDR_W, OP_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_dd;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_result;
  logic              r_carry_res;
  logic [DATA_W-1:0] r_q_final;
  logic              r_q_valid;
  logic              r_q_zero;
  logic              r_q_carry;
  logic              r_q_err;

  logic [ADDR_W-1:0] w_da;
  logic [ADDR_W-1:0] w_db;
  logic [ADDR_W-1:0] w_dd;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic              w_legal;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_prod;
  logic [DATA_W-1:0] w_wb_res;

  assign w_da = instr[DA_LSB +: ADDR_W];
  assign w_db = instr[DB_LSB +: ADDR_W];
  assign w_dd = instr[DD_LSB +: ADDR_W];
  assign w_op = instr[OP_W-1:0];

  assign instr_ready = (r_state == IDLE);
  assign q_final     = r_q_final;
  assign q_valid     = r_q_valid;
  assign q_zero      = r_q_zero;
  assign q_carry     = r_q_carry;
  assign q_err       = r_q_err;

  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_is_mul = (r_op == OP_W'(OP_MUL));

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_legal     = 1'b1;
    case (r_op)
      OP_W'(OP_ADD): begin
        w_alu_res   = w_sum[DATA_W-1:0];
        w_alu_carry = w_sum[DATA_W];
      end
      OP_W'(OP_SUB): begin
        w_alu_res   = r_a - r_b;
        w_alu_carry = (r_a < r_b);
      end
      OP_W'(OP_AND): w_alu_res = r_a & r_b;
      OP_W'(OP_OR):  w_alu_res = r_a | r_b;
      OP_W'(OP_XOR): w_alu_res = r_a ^ r_b;
      OP_W'(OP_MUL): w_alu_res = '0;
      default:       w_legal   = 1'b0;
    endcase
  end

  // Multiplier is kicked off from EXEC; it loads its own copies of A and B.
  assign w_mul_start = (r_state == EXEC) && w_is_mul;

  chocorol_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // In WB the multiplier accumulator already holds the final product.
  assign w_wb_res = w_is_mul ? w_mul_prod : r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_dd        <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_carry_res <= 1'b0;
      r_q_final   <= '0;
      r_q_valid   <= 1'b0;
      r_q_zero    <= 1'b0;
      r_q_carry   <= 1'b0;
      r_q_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_q_valid <= 1'b0;
      r_q_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          // Operand reads below see the pre-load contents (NBA semantics).
          if (ld_en) r_mem[ld_addr] <= ld_data;
          if (instr_valid) begin
            r_a     <= r_mem[w_da];
            r_b     <= r_mem[w_db];
            r_dd    <= w_dd;
            r_op    <= w_op;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (!w_legal) begin
            r_q_err <= 1'b1;
            r_state <= IDLE;
          end else if (w_is_mul) begin
            r_carry_res <= 1'b0;
            r_state     <= MUL;
          end else begin
            r_result    <= w_alu_res;
            r_carry_res <= w_alu_carry;
            r_state     <= WB;
          end
        end
        MUL: begin
          if (w_mul_done) r_state <= WB;
        end
        WB: begin
          r_mem[r_dd] <= w_wb_res;
          r_q_final   <= w_wb_res;
          r_q_zero    <= (w_wb_res == '0);
          r_q_carry   <= r_carry_res;
          r_q_valid   <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chocorol_seq.sv
module tb_chocorol_seq;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int OW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [3*AW+OW-1:0] instr = '0;
  logic              ld_en = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [DW-1:0]     ld_data = '0;
  logic [DW-1:0]     q_final;
  logic              q_valid;
  logic              q_zero;
  logic              q_carry;
  logic              q_err;

  chocorol_seq #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .q_final     (q_final),
    .q_valid     (q_valid),
    .q_zero      (q_zero),
    .q_carry     (q_carry),
    .q_err       (q_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    bit            is_err;
    logic [DW-1:0] data;
    bit            zero;
    bit            carry;
    int            due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && (q_valid || q_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: q_valid=%0b q_err=%0b q_final=%0h at cycle %0d with nothing expected",
                 q_valid, q_err, q_final, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_err"}, 64'(q_err), 64'(e.is_err));
        chk({e.name, "_valid"}, 64'(q_valid), 64'(!e.is_err));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
        if (!e.is_err) begin
          chk({e.name, "_q"}, 64'(q_final), 64'(e.data));
          chk({e.name, "_zero"}, 64'(q_zero), 64'(e.zero));
          chk({e.name, "_carry"}, 64'(q_carry), 64'(e.carry));
        end
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input string name, input logic [AW-1:0] da, db, dd,
                       input logic [OW-1:0] op, input bit push, input bit is_err,
                       input logic [DW-1:0] q, input bit z, input bit c, input int lat,
                       input bit do_ld, input logic [AW-1:0] la, input logic [DW-1:0] ldv,
                       output int acc, output int waits);
    instr_valid = 1'b1;
    instr = {da, db, dd, op};
    ld_en = do_ld; ld_addr = la; ld_data = ldv;
    waits = 0;
    acc = 0;
    while (!instr_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: instr_ready stayed 0 for %0d cycles, required 1", name, waits);
      instr_valid = 1'b0; ld_en = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    instr_valid = 1'b0;
    ld_en = 1'b0;
    instr = '1;  // junk while busy; must be ignored
    if (push) sb.push_back('{name, is_err, q, z, c, acc + lat});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || !instr_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic alu(input string name, input logic [AW-1:0] da, db, dd,
                     input logic [OW-1:0] op, input logic [DW-1:0] q, input bit z, input bit c);
    int a, w;
    issue(name, da, db, dd, op, 1'b1, 1'b0, q, z, c, 2, 1'b0, '0, '0, a, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, w;
    repeat (3) @(negedge clk);
    chk("rst_q_final", 64'(q_final), 64'd0);
    chk("rst_q_valid", 64'(q_valid), 64'd0);
    chk("rst_q_zero",  64'(q_zero),  64'd0);
    chk("rst_q_carry", 64'(q_carry), 64'd0);
    chk("rst_q_err",   64'(q_err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'd1);

    preload(6'd0, 32'd25);
    preload(6'd1, 32'd17);
    alu("add_basic", 6'd0, 6'd1, 6'd8, 8'd0, 32'd42, 1'b0, 1'b0);
    alu("read_m8", 6'd8, 6'd8, 6'd10, 8'd3, 32'd42, 1'b0, 1'b0);
    drain("t1");

    preload(6'd2, 32'd5);
    preload(6'd3, 32'd9);
    preload(6'd4, 32'h0F0F);
    preload(6'd5, 32'h0F0F);
    preload(6'd12, 32'hF0F0_1234);
    preload(6'd13, 32'h0FF0_FF00);
    alu("sub_borrow", 6'd2, 6'd3, 6'd9, 8'd1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    alu("sub_noborrow", 6'd3, 6'd2, 6'd19, 8'd1, 32'd4, 1'b0, 1'b0);
    alu("xor_zero", 6'd4, 6'd5, 6'd11, 8'd4, 32'd0, 1'b1, 1'b0);
    alu("and", 6'd12, 6'd13, 6'd18, 8'd2, 32'h00F0_1200, 1'b0, 1'b0);

    // MUL, with the next instruction held valid throughout the multiply.
    issue("mul", 6'd0, 6'd1, 6'd14, 8'd7, 1'b1, 1'b0, 32'd425, 1'b0, 1'b0, 34,
          1'b0, '0, '0, a1, w);
    issue("add_after_mul", 6'd14, 6'd0, 6'd15, 8'd0, 1'b1, 1'b0, 32'd450, 1'b0, 1'b0, 2,
          1'b0, '0, '0, a2, w);
    chk("mul_ready_low_cycles", 64'(w), 64'd34);
    chk("mul_next_accept", 64'(a2 - a1), 64'd35);
    drain("t3");

    issue("illegal_05", 6'd0, 6'd1, 6'd8, 8'h05, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1,
          1'b0, '0, '0, a1, w);
    drain("t4");
    chk("err_q_final_kept", 64'(q_final), 64'd450);
    chk("err_q_zero_kept",  64'(q_zero),  64'd0);
    alu("m8_unchanged", 6'd8, 6'd8, 6'd16, 8'd3, 32'd42, 1'b0, 1'b0);
    issue("illegal_ff", 6'd0, 6'd0, 6'd0, 8'hFF, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1,
          1'b0, '0, '0, a1, w);
    drain("t4b");

    preload(6'd6, 32'hFFFF_FFFF);
    preload(6'd7, 32'd1);
    alu("add_wrap", 6'd6, 6'd7, 6'd6, 8'd0, 32'd0, 1'b1, 1'b1);
    alu("read_m6", 6'd6, 6'd6, 6'd17, 8'd3, 32'd0, 1'b1, 1'b0);
    drain("t5");

    // Load and instruction in the same cycle: instruction sees the old word.
    issue("ld_same_cycle", 6'd20, 6'd0, 6'd21, 8'd0, 1'b1, 1'b0, 32'd25, 1'b0, 1'b0, 2,
          1'b1, 6'd20, 32'd99, a1, w);
    alu("ld_took_effect", 6'd20, 6'd20, 6'd22, 8'd3, 32'd99, 1'b0, 1'b0);
    drain("t6");

    preload(6'd26, 32'h0001_0000);
    preload(6'd27, 32'h0001_0001);
    issue("mul_trunc", 6'd26, 6'd27, 6'd28, 8'd7, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 34,
          1'b0, '0, '0, a1, w);
    drain("t7");

    // Reset during a multiply: nothing must come out and memory clears.
    issue("mul_killed", 6'd0, 6'd1, 6'd23, 8'd7, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0,
          1'b0, '0, '0, a1, w);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_q_final", 64'(q_final), 64'd0);
    chk("midrst_q_valid", 64'(q_valid), 64'd0);
    chk("midrst_ready",   64'(instr_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", 64'(instr_ready), 64'd1);
    repeat (40) @(negedge clk);
    alu("m23_zero", 6'd23, 6'd23, 6'd24, 8'd3, 32'd0, 1'b1, 1'b0);
    alu("mem_cleared", 6'd0, 6'd1, 6'd25, 8'd3, 32'd0, 1'b1, 1'b0);
    drain("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
